// File: rtl/upd78xx_intc.sv
// upd78xx_intc: maskable, prioritised, vectored interrupt controller for
// uPD78xx cores. Synchronises raw lines, latches edge sources, picks the
// lowest eligible index and hands one frozen request to the CPU.
module upd78xx_intc #(
  parameter int unsigned NSRC        = 4,
  parameter logic [15:0] VEC_BASE    = 16'h0004,
  parameter int unsigned VEC_STRIDE  = 4,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned SRC_W      = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic             CLK,
  input  logic             RESETB,
  input  logic             CE,
  input  logic [NSRC-1:0]  IRQ_IN,
  input  logic [NSRC-1:0]  EDGE_MODE,
  input  logic             MASK_WE,
  input  logic [NSRC-1:0]  MASK_D,
  output logic [NSRC-1:0]  MASK_Q,
  input  logic [NSRC-1:0]  SW_SET,
  input  logic [NSRC-1:0]  CLR,
  input  logic             IE,
  output logic             INT_REQ,
  output logic [SRC_W-1:0] INT_SRC,
  output logic [15:0]      INT_VEC,
  input  logic             INT_ACK,
  output logic [NSRC-1:0]  PEND
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

  logic [NSRC-1:0]  sync_q [SYNC_STAGES];
  logic [NSRC-1:0]  prev_q;
  logic [NSRC-1:0]  latch_q;
  logic [NSRC-1:0]  mask_q;
  logic [NSRC-1:0]  s_last;
  logic [NSRC-1:0]  rise;
  logic [NSRC-1:0]  eligible;
  logic [NSRC-1:0]  src_onehot;
  logic [NSRC-1:0]  ack_clr;
  logic [SRC_W-1:0] win_idx;
  logic [SRC_W-1:0] src_q;
  logic [15:0]      vec_q;
  logic             any_eligible;
  logic             frozen_eligible;
  state_t           state_q;
  state_t           state_d;

  // Vector for a source index; the product wraps to 16 bits before the add.
  function automatic logic [15:0] vec_of(input logic [SRC_W-1:0] idx);
    logic [31:0] prod;
    prod = 32'(idx) * VEC_STRIDE;
    return VEC_BASE + prod[15:0];
  endfunction

  assign s_last          = sync_q[SYNC_STAGES-1];
  assign rise            = s_last & ~prev_q;
  assign PEND            = (latch_q & EDGE_MODE) | (s_last & ~EDGE_MODE);
  assign eligible        = PEND & ~mask_q & {NSRC{IE}};
  assign any_eligible    = |eligible;
  assign src_onehot      = NSRC'(1) << src_q;
  assign frozen_eligible = |(eligible & src_onehot);
  assign ack_clr         = (state_q == S_REQ && INT_ACK) ? src_onehot : '0;
  assign MASK_Q          = mask_q;
  assign INT_SRC         = src_q;
  assign INT_VEC         = vec_q;

  // Synchroniser chain plus edge-history flop, advancing only on CE.
  always_ff @(posedge CLK) begin
    if (!RESETB) begin
      for (int k = 0; k < int'(SYNC_STAGES); k++) sync_q[k] <= '0;
      prev_q <= '0;
    end else if (CE) begin
      sync_q[0] <= IRQ_IN;
      for (int k = 1; k < int'(SYNC_STAGES); k++) sync_q[k] <= sync_q[k-1];
      prev_q <= s_last;
    end
  end

  // Edge latches (set beats clear; dropped for level sources) and mask.
  always_ff @(posedge CLK) begin
    if (!RESETB) begin
      latch_q <= '0;
      mask_q  <= '1;
    end else begin
      latch_q <= ((latch_q & ~(CLR | ack_clr)) | ({NSRC{CE}} & rise) | SW_SET)
                 & EDGE_MODE;
      if (MASK_WE) mask_q <= MASK_D;
    end
  end

  // Lowest eligible index wins.
  always_comb begin
    win_idx = '0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (eligible[i]) win_idx = SRC_W'(i);
    end
  end

  // FSM state register; source and vector are captured only when leaving IDLE.
  always_ff @(posedge CLK) begin
    if (!RESETB) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      vec_q   <= VEC_BASE;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && any_eligible) begin
        src_q <= win_idx;
        vec_q <= vec_of(win_idx);
      end
    end
  end

  // FSM next state: ack beats withdraw, HOLD forces a one-clock gap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_eligible) state_d = S_REQ;
      S_REQ: begin
        if (INT_ACK)               state_d = S_HOLD;
        else if (!frozen_eligible) state_d = S_IDLE;
      end
      S_HOLD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: request is asserted exactly while in REQ.
  always_comb begin
    INT_REQ = (state_q == S_REQ);
  end

endmodule
